game_flow_sequencer: RTL and testbench

//  Top-level game-phase FSM for the fish game. It sequences title -> play -> result -> title

---
 rtl/game_flow_sequencer.sv | 173 +++++++++++++++++
 tb/tb_game_flow_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_sequencer.sv
// Game-phase sequencer for the fish game: title -> play -> result -> title.
// Drives the overlay select, the play enable and a one-cycle restart pulse.
module game_flow_sequencer #(
  parameter logic [7:0]  ENTER_KEY    = 8'h28,
  parameter logic [8:0]  TOTAL_FISH   = 9'd9,
  parameter logic [15:0] ROUND_FRAMES = 16'd3600,
  parameter logic [7:0]  HOLD_FRAMES  = 8'd120
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_start_i,
  input  logic [7:0]  keycode_i,
  input  logic [7:0]  keycode_0_i,
  input  logic        user1_dead_i,
  input  logic        user2_dead_i,
  input  logic [7:0]  score1_i,
  input  logic [7:0]  score2_i,
  output logic [1:0]  screen_sel_o,
  output logic        game_run_o,
  output logic        play_reset_o,
  output logic [1:0]  winner_o,
  output logic [15:0] time_left_o,
  output logic [2:0]  state_o
);

  localparam logic [2:0] ST_TITLE     = 3'd0;
  localparam logic [2:0] ST_PLAY      = 3'd1;
  localparam logic [2:0] ST_OVER_HOLD = 3'd2;
  localparam logic [2:0] ST_OVER_WAIT = 3'd3;

  localparam logic [1:0] SEL_GAME  = 2'd0;
  localparam logic [1:0] SEL_START = 2'd1;
  localparam logic [1:0] SEL_P1WIN = 2'd2;
  localparam logic [1:0] SEL_P2WIN = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [15:0] time_left_q, time_left_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  winner_q, winner_d;
  logic        enter_q;
  logic        play_reset_q, play_reset_d;
  logic [1:0]  screen_sel_q, screen_sel_d;
  logic        game_run_q, game_run_d;

  logic        enter;
  logic        enter_rise;
  logic [8:0]  score_sum;
  logic [1:0]  score_winner;
  logic        end_hit;
  logic [1:0]  end_winner;

  assign enter      = (keycode_i == ENTER_KEY) | (keycode_0_i == ENTER_KEY);
  assign enter_rise = enter & ~enter_q;
  assign score_sum  = {1'b0, score1_i} + {1'b0, score2_i};

  always_comb begin
    if (score1_i > score2_i)      score_winner = 2'd1;
    else if (score2_i > score1_i) score_winner = 2'd2;
    else                          score_winner = 2'd3;
  end

  // Round-end detection in priority order; masked while the datapath is being cleared.
  always_comb begin
    end_hit    = 1'b0;
    end_winner = 2'd0;
    if (!play_reset_q) begin
      if (user1_dead_i && user2_dead_i) begin
        end_hit    = 1'b1;
        end_winner = score_winner;
      end else if (user1_dead_i) begin
        end_hit    = 1'b1;
        end_winner = 2'd2;
      end else if (user2_dead_i) begin
        end_hit    = 1'b1;
        end_winner = 2'd1;
      end else if (score_sum >= TOTAL_FISH) begin
        end_hit    = 1'b1;
        end_winner = score_winner;
      end else if (time_left_q == 16'd0) begin
        end_hit    = 1'b1;
        end_winner = score_winner;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    time_left_d  = time_left_q;
    hold_cnt_d   = hold_cnt_q;
    winner_d     = winner_q;
    play_reset_d = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (enter_rise) begin
          state_d      = ST_PLAY;
          play_reset_d = 1'b1;
          time_left_d  = ROUND_FRAMES;
          winner_d     = 2'd0;
        end
      end
      ST_PLAY: begin
        if (end_hit) begin
          state_d    = ST_OVER_HOLD;
          hold_cnt_d = 8'd0;
          winner_d   = end_winner;
        end else if (frame_start_i && (time_left_q != 16'd0)) begin
          time_left_d = time_left_q - 16'd1;
        end
      end
      ST_OVER_HOLD: begin
        if (frame_start_i) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          if (hold_cnt_q == HOLD_FRAMES - 8'd1) state_d = ST_OVER_WAIT;
        end
      end
      ST_OVER_WAIT: begin
        if (enter_rise) state_d = ST_TITLE;
      end
      default: begin
        state_d     = ST_TITLE;
        time_left_d = ROUND_FRAMES;
        winner_d    = 2'd0;
        hold_cnt_d  = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_comb begin
    screen_sel_d = SEL_START;
    case (state_d)
      ST_TITLE: screen_sel_d = SEL_START;
      ST_PLAY:  screen_sel_d = SEL_GAME;
      ST_OVER_HOLD, ST_OVER_WAIT: begin
        if (winner_d == 2'd1)      screen_sel_d = SEL_P1WIN;
        else if (winner_d == 2'd2) screen_sel_d = SEL_P2WIN;
        else                       screen_sel_d = SEL_GAME;
      end
      default: screen_sel_d = SEL_START;
    endcase
    game_run_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_TITLE;
      time_left_q  <= ROUND_FRAMES;
      hold_cnt_q   <= 8'd0;
      winner_q     <= 2'd0;
      enter_q      <= 1'b0;
      play_reset_q <= 1'b0;
      screen_sel_q <= SEL_START;
      game_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_left_q  <= time_left_d;
      hold_cnt_q   <= hold_cnt_d;
      winner_q     <= winner_d;
      enter_q      <= enter;
      play_reset_q <= play_reset_d;
      screen_sel_q <= screen_sel_d;
      game_run_q   <= game_run_d;
    end
  end

  assign screen_sel_o = screen_sel_q;
  assign game_run_o   = game_run_q;
  assign play_reset_o = play_reset_q;
  assign winner_o     = winner_q;
  assign time_left_o  = time_left_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Bench for game_flow_sequencer: directed steps plus randomized rounds checked
// against a rule-level model of how a round ends and what the overlay shows.
module tb_game_flow_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic [7:0]  keycode_0 = 8'd0;
  logic        u1_dead = 1'b0;
  logic        u2_dead = 1'b0;
  logic [7:0]  score1 = 8'd0;
  logic [7:0]  score2 = 8'd0;
  logic [1:0]  screen_sel;
  logic        game_run;
  logic        play_reset;
  logic [1:0]  winner;
  logic [15:0] time_left;
  logic [2:0]  state;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_time;
  logic [1:0]  exp_win;

  game_flow_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_start_i(frame_start),
    .keycode_i    (keycode),
    .keycode_0_i  (keycode_0),
    .user1_dead_i (u1_dead),
    .user2_dead_i (u2_dead),
    .score1_i     (score1),
    .score2_i     (score2),
    .screen_sel_o (screen_sel),
    .game_run_o   (game_run),
    .play_reset_o (play_reset),
    .winner_o     (winner),
    .time_left_o  (time_left),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Who wins given the inputs seen by a live round; 0 means the round continues.
  function automatic logic [1:0] ref_winner(input bit d1, input bit d2, input int s1,
                                            input int s2, input int tl);
    int by_score;
    by_score = (s1 > s2) ? 1 : (s2 > s1) ? 2 : 3;
    if (d1 && d2)        return 2'(by_score);
    if (d1)              return 2'd2;
    if (d2)              return 2'd1;
    if (s1 + s2 >= 9)    return 2'(by_score);
    if (tl == 0)         return 2'(by_score);
    return 2'd0;
  endfunction

  function automatic logic [1:0] ref_sel(input logic [1:0] w);
    return (w == 2'd1) ? 2'd2 : (w == 2'd2) ? 2'd3 : 2'd0;
  endfunction

  task automatic clear_inputs();
    u1_dead = 1'b0; u2_dead = 1'b0; score1 = 8'd0; score2 = 8'd0;
    keycode = 8'd0; keycode_0 = 8'd0; frame_start = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic start_round();
    clear_inputs();
    tick();
    keycode = 8'h28;
    tick();
    check("start_state", 32'(state), 32'd1);
    check("start_pulse", 32'(play_reset), 32'd1);
    check("start_time", 32'(time_left), 32'd3600);
    check("start_winner", 32'(winner), 32'd0);
    keycode = 8'd0;
    tick();
    check("start_pulse_end", 32'(play_reset), 32'd0);
    exp_time = 16'd3600;
  endtask

  task automatic check_over(input string tag, input logic [1:0] w);
    check({tag, "_state"}, 32'(state), 32'd2);
    check({tag, "_winner"}, 32'(winner), 32'(w));
    check({tag, "_sel"}, 32'(screen_sel), 32'(ref_sel(w)));
    check({tag, "_run"}, 32'(game_run), 32'd0);
    exp_win = w;
  endtask

  // Enter noise throughout the hold period must be ignored; a fresh rise afterwards returns to title.
  task automatic finish_hold();
    clear_inputs();
    for (int k = 1; k <= 120; k++) begin
      if ($urandom_range(0, 1) == 1) keycode = 8'h28; else keycode = 8'd0;
      if ($urandom_range(0, 3) == 0) keycode_0 = 8'h28; else keycode_0 = 8'd0;
      frame_pulse();
      if (k == 119) check("hold_119", 32'(state), 32'd2);
    end
    keycode = 8'd0; keycode_0 = 8'd0;
    tick();
    check("wait_state", 32'(state), 32'd3);
    check("wait_winner", 32'(winner), 32'(exp_win));
    keycode_0 = 8'h28;
    tick();
    check("title_state", 32'(state), 32'd0);
    check("title_sel", 32'(screen_sel), 32'd1);
    check("title_winner_kept", 32'(winner), 32'(exp_win));
    keycode_0 = 8'd0;
    tick();
  endtask

  initial begin
    int pulses;
    bit d1, d2;
    int s1, s2, nf;
    logic [1:0] w;

    #1 rst_n = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_sel", 32'(screen_sel), 32'd1);
    check("rst_run", 32'(game_run), 32'd0);
    check("rst_pulse", 32'(play_reset), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_time", 32'(time_left), 32'd3600);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Enter held for 10 cycles on slot 1 gives exactly one restart pulse.
    keycode_0 = 8'h28;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (play_reset) pulses++;
    end
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_state", 32'(state), 32'd1);
    check("held_sel", 32'(screen_sel), 32'd0);
    check("held_run", 32'(game_run), 32'd1);
    keycode_0 = 8'd0;
    tick();

    u2_dead = 1'b1;
    tick();
    check_over("p2dead", 2'd1);
    finish_hold();

    start_round();
    u1_dead = 1'b1; u2_dead = 1'b1; score1 = 8'd3; score2 = 8'd5;
    tick();
    check_over("bothdead", 2'd2);
    finish_hold();

    // A dead flag left over from the previous round is ignored while the restart pulse is high.
    clear_inputs();
    u2_dead = 1'b1;
    tick();
    keycode = 8'h28;
    tick();
    keycode = 8'd0;
    tick();
    check("stale_state", 32'(state), 32'd1);
    tick();
    check_over("stale_end", 2'd1);
    finish_hold();

    start_round();
    score1 = 8'd4; score2 = 8'd4;
    tick();
    check("sum8_state", 32'(state), 32'd1);
    score2 = 8'd5;
    tick();
    check_over("sum9_p2", 2'd2);
    finish_hold();

    start_round();
    score1 = 8'd5; score2 = 8'd4;
    tick();
    check_over("sum9_p1", 2'd1);
    finish_hold();

    // Full round timeout with equal scores is a draw showing the frozen game.
    start_round();
    score1 = 8'd2; score2 = 8'd2;
    for (int k = 1; k <= 3600; k++) begin
      frame_pulse();
      if (k == 1) check("timer_1", 32'(time_left), 32'd3599);
      if (k == 3599) check("timer_3599", 32'(time_left), 32'd1);
    end
    check("timer_zero", 32'(time_left), 32'd0);
    check_over("timeout", 2'd3);
    finish_hold();

    for (int r = 0; r < 8; r++) begin
      start_round();
      nf = int'($urandom_range(0, 4));
      for (int k = 0; k < nf; k++) frame_pulse();
      exp_time = exp_time - 16'(nf);
      check("rnd_time", 32'(time_left), 32'(exp_time));
      s1 = int'($urandom_range(0, 8));
      s2 = int'($urandom_range(0, 8));
      d1 = ($urandom_range(0, 3) == 0);
      d2 = ($urandom_range(0, 3) == 0);
      score1 = 8'(s1); score2 = 8'(s2); u1_dead = d1; u2_dead = d2;
      tick();
      w = ref_winner(d1, d2, s1, s2, int'(exp_time));
      if (w == 2'd0) begin
        check("rnd_continue", 32'(state), 32'd1);
        u1_dead = 1'b1;
        tick();
        w = ref_winner(1'b1, d2, s1, s2, int'(exp_time));
      end
      check_over("rnd_end", w);
      finish_hold();
    end

    // Asynchronous reset in the middle of a round.
    start_round();
    for (int k = 0; k < 3; k++) frame_pulse();
    check("mid_time", 32'(time_left), 32'd3597);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_time", 32'(time_left), 32'd3600);
    check("arst_sel", 32'(screen_sel), 32'd1);
    check("arst_run", 32'(game_run), 32'd0);
    check("arst_pulse", 32'(play_reset), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_pulse", 32'(play_reset), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
